// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// ALU, memory port, IR and PC, decoding addu, subu, ori, lw, sw, beq, lui, j, jal, jr.
// Optional feature macro: MEM_WAIT_EN (MEM waits on mem_ready, with a timeout after MEM_WAIT_MAX cycles).
module mc_controller #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic [3:0] ext_op,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_err
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_NOP   = 6'h00;
  localparam logic [OP_W-1:0] FN_JR    = 6'h08;
  localparam logic [OP_W-1:0] FN_ADDU  = 6'h21;
  localparam logic [OP_W-1:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] PC_SRC_ALU  = 2'd0;
  localparam logic [1:0] PC_SRC_BR   = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP = 2'd2;
  localparam logic [1:0] PC_SRC_RS   = 2'd3;

  localparam logic [1:0] B_RT   = 2'd0;
  localparam logic [1:0] B_FOUR = 2'd1;
  localparam logic [1:0] B_EXT  = 2'd2;
  localparam logic [1:0] B_BR   = 2'd3;

  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  localparam logic [3:0] EXT_SIGN  = 4'b1000;
  localparam logic [3:0] EXT_ZERO  = 4'b0100;
  localparam logic [3:0] EXT_UPPER = 4'b0010;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_J, K_JAL, K_JR, K_NOP, K_ILL
  } kind_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [3:0] ext_op;
    logic       instr_done;
    logic       illegal;
    logic       mem_err;
  } ctrl_t;

  state_e state_q, state_d;
  kind_e  kind_c;
  ctrl_t  ctrl_c, ctrl_g;
  logic   mem_go_c;
  logic   unused_c;

  // Classify the instruction held in IR
  always_comb begin
    kind_c = K_ILL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: kind_c = K_ADDU;
          FN_SUBU: kind_c = K_SUBU;
          FN_JR:   kind_c = K_JR;
          FN_NOP:  kind_c = K_NOP;
          default: kind_c = K_ILL;
        endcase
      end
      OP_ORI:  kind_c = K_ORI;
      OP_LW:   kind_c = K_LW;
      OP_SW:   kind_c = K_SW;
      OP_BEQ:  kind_c = K_BEQ;
      OP_LUI:  kind_c = K_LUI;
      OP_J:    kind_c = K_J;
      OP_JAL:  kind_c = K_JAL;
      default: kind_c = K_ILL;
    endcase
  end

`ifdef MEM_WAIT_EN
  localparam int unsigned WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

  logic [WAIT_W-1:0] wait_q, wait_d;

  // Count MEM cycles; cleared whenever outside MEM so each entry starts at zero
  always_comb begin
    wait_d = '0;
    if (state_q == S_MEM) wait_d = wait_q + WAIT_W'(1);
  end

  // Wait counter register
  always_ff @(posedge clk) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end

  assign unused_c = zero;
`else
  assign unused_c = ^{zero, mem_ready, 32'(MEM_WAIT_MAX)};
`endif

  // Next-state and datapath control for the current state
  always_comb begin
    ctrl_c   = '0;
    state_d  = state_q;
    mem_go_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.ir_write  = 1'b1;
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_src    = PC_SRC_ALU;
        ctrl_c.alu_src_b = B_FOUR;
        ctrl_c.alu_ctrl  = ALU_ADD;
        state_d          = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is always precomputed into ALUOut here
        ctrl_c.alu_src_b = B_BR;
        ctrl_c.alu_ctrl  = ALU_ADD;
        case (kind_c)
          K_J: begin
            ctrl_c.pc_write   = 1'b1;
            ctrl_c.pc_src     = PC_SRC_JUMP;
            ctrl_c.instr_done = 1'b1;
            state_d           = S_FETCH;
          end
          K_JAL: begin
            ctrl_c.pc_write   = 1'b1;
            ctrl_c.pc_src     = PC_SRC_JUMP;
            ctrl_c.reg_write  = 1'b1;
            ctrl_c.reg_dst    = DST_RA;
            ctrl_c.mem_to_reg = M2R_PC;
            ctrl_c.instr_done = 1'b1;
            state_d           = S_FETCH;
          end
          K_JR: begin
            ctrl_c.pc_write   = 1'b1;
            ctrl_c.pc_src     = PC_SRC_RS;
            ctrl_c.instr_done = 1'b1;
            state_d           = S_FETCH;
          end
          K_NOP: begin
            ctrl_c.instr_done = 1'b1;
            state_d           = S_FETCH;
          end
          K_ILL: begin
            ctrl_c.illegal    = 1'b1;
            ctrl_c.instr_done = 1'b1;
            state_d           = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        case (kind_c)
          K_ADDU: begin
            ctrl_c.alu_src_b = B_RT;
            ctrl_c.alu_ctrl  = ALU_ADD;
            state_d          = S_WB;
          end
          K_SUBU: begin
            ctrl_c.alu_src_b = B_RT;
            ctrl_c.alu_ctrl  = ALU_SUB;
            state_d          = S_WB;
          end
          K_ORI: begin
            ctrl_c.alu_src_b = B_EXT;
            ctrl_c.alu_ctrl  = ALU_OR;
            ctrl_c.ext_op    = EXT_ZERO;
            state_d          = S_WB;
          end
          K_LUI: begin
            // rs is $0 in the encoding, so rs + (imm<<16) yields the upper immediate
            ctrl_c.alu_src_b = B_EXT;
            ctrl_c.alu_ctrl  = ALU_ADD;
            ctrl_c.ext_op    = EXT_UPPER;
            state_d          = S_WB;
          end
          K_LW, K_SW: begin
            ctrl_c.alu_src_b = B_EXT;
            ctrl_c.alu_ctrl  = ALU_ADD;
            ctrl_c.ext_op    = EXT_SIGN;
            state_d          = S_MEM;
          end
          K_BEQ: begin
            ctrl_c.alu_src_b     = B_RT;
            ctrl_c.alu_ctrl      = ALU_SUB;
            ctrl_c.pc_write_cond = 1'b1;
            ctrl_c.pc_src        = PC_SRC_BR;
            ctrl_c.instr_done    = 1'b1;
            state_d              = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        ctrl_c.mem_read  = (kind_c == K_LW);
        ctrl_c.mem_write = (kind_c == K_SW);
`ifdef MEM_WAIT_EN
        if (mem_ready) begin
          mem_go_c = 1'b1;
        end else if (wait_q == WAIT_W'(MEM_WAIT_MAX - 1)) begin
          ctrl_c.mem_err    = 1'b1;
          ctrl_c.instr_done = 1'b1;
          state_d           = S_FETCH;
        end
`else
        mem_go_c = 1'b1;
`endif
        if (mem_go_c) begin
          if (kind_c == K_LW) begin
            state_d = S_WB;
          end else begin
            ctrl_c.instr_done = 1'b1;
            state_d           = S_FETCH;
          end
        end
      end
      S_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.instr_done = 1'b1;
        ctrl_c.reg_dst    = DST_RT;
        ctrl_c.mem_to_reg = M2R_ALU;
        case (kind_c)
          K_ADDU, K_SUBU: ctrl_c.reg_dst    = DST_RD;
          K_LW:           ctrl_c.mem_to_reg = M2R_MDR;
          default:        ctrl_c.reg_dst    = DST_RT;
        endcase
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign ctrl_g = reset ? '0 : ctrl_c;

  assign {pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write, reg_write,
          reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, ext_op,
          instr_done, illegal, mem_err} = ctrl_g;

  assign state = STATE_W'(state_q);

endmodule
